// File: rtl/core_dmem.sv
// Data-memory responder for the core load/store bus: word RAM plus an I/O page holding a
// 64-bit cycle counter with snapshot, GPIO out/in and a sticky bus-error flag.
module core_dmem #(
    parameter int unsigned RAM_DEPTH = 4096,
    parameter int unsigned GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_in,
    input  logic              mem_rw_in,
    input  logic [31:0]       mem_addr_in,
    input  logic [31:0]       mem_wdata_in,
    output logic [31:0]       mem_rdata_out,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              err_out
);

    localparam int unsigned AW = $clog2(RAM_DEPTH);

    localparam logic [29:0] WaCntLo   = 30'h0400_0000;
    localparam logic [29:0] WaCntHi   = 30'h0400_0001;
    localparam logic [29:0] WaGpioOut = 30'h0400_0002;
    localparam logic [29:0] WaGpioIn  = 30'h0400_0003;
    localparam logic [29:0] WaErr     = 30'h0400_0004;

    typedef enum logic [2:0] {
        TgtNone,
        TgtRam,
        TgtCntLo,
        TgtCntHi,
        TgtGpioOut,
        TgtGpioIn,
        TgtErr
    } tgt_e;

    logic [31:0]       ram_q [RAM_DEPTH];
    logic [63:0]       counter_q,  counter_d;
    logic [31:0]       shadow_hi_q, shadow_hi_d;
    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] sync1_q,    sync1_d;
    logic [GPIO_W-1:0] sync2_q,    sync2_d;
    logic              err_q,      err_d;

    tgt_e              tgt;
    logic [29:0]       wa;
    logic [AW-1:0]     ram_idx;
    logic              wr_en;
    logic              rd_en;
    logic              ram_we;
    logic              unused_addr;

    assign wa          = mem_addr_in[31:2];
    assign ram_idx     = mem_addr_in[AW+1:2];
    assign wr_en       = mem_req_in & mem_rw_in;
    assign rd_en       = mem_req_in & ~mem_rw_in;
    assign ram_we      = wr_en && (tgt == TgtRam);
    assign unused_addr = ^mem_addr_in[1:0];

    // RAM hit needs the top nibble clear and no address bits above the RAM size.
    always_comb begin
        tgt = TgtNone;
        if ((mem_addr_in[31:28] == 4'h0) && (mem_addr_in[31:AW+2] == '0)) begin
            tgt = TgtRam;
        end else begin
            unique case (wa)
                WaCntLo:   tgt = TgtCntLo;
                WaCntHi:   tgt = TgtCntHi;
                WaGpioOut: tgt = TgtGpioOut;
                WaGpioIn:  tgt = TgtGpioIn;
                WaErr:     tgt = TgtErr;
                default:   tgt = TgtNone;
            endcase
        end
    end

    always_comb begin
        mem_rdata_out = '0;
        if (mem_req_in) begin
            unique case (tgt)
                TgtRam:     mem_rdata_out = ram_q[ram_idx];
                TgtCntLo:   mem_rdata_out = counter_q[31:0];
                TgtCntHi:   mem_rdata_out = shadow_hi_q;
                TgtGpioOut: mem_rdata_out[GPIO_W-1:0] = gpio_out_q;
                TgtGpioIn:  mem_rdata_out[GPIO_W-1:0] = sync2_q;
                TgtErr:     mem_rdata_out[0] = err_q;
                default:    mem_rdata_out = '0;
            endcase
        end
    end

    always_comb begin
        counter_d   = counter_q + 64'd1;
        shadow_hi_d = shadow_hi_q;
        gpio_out_d  = gpio_out_q;
        sync1_d     = gpio_in;
        sync2_d     = sync1_q;
        err_d       = err_q;

        // Counter writes replace the increment for that cycle.
        if (wr_en && (tgt == TgtCntLo)) begin
            counter_d = {counter_q[63:32], mem_wdata_in};
        end else if (wr_en && (tgt == TgtCntHi)) begin
            counter_d = {mem_wdata_in, counter_q[31:0]};
        end

        if (rd_en && (tgt == TgtCntLo)) begin
            shadow_hi_d = counter_q[63:32];
        end

        if (wr_en && (tgt == TgtGpioOut)) begin
            gpio_out_d = mem_wdata_in[GPIO_W-1:0];
        end

        // Set wins over clear.
        if (mem_req_in && (tgt == TgtNone)) begin
            err_d = 1'b1;
        end else if (wr_en && (tgt == TgtErr)) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_q   <= '0;
            shadow_hi_q <= '0;
            gpio_out_q  <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            shadow_hi_q <= shadow_hi_d;
            gpio_out_q  <= gpio_out_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= mem_wdata_in;
        end
    end

    assign gpio_out = gpio_out_q;
    assign err_out  = err_q;

endmodule

// File: tb/tb_core_dmem.sv
// Randomised bench for core_dmem against a behavioural model of the bus-visible state.
module tb_core_dmem;

    localparam int unsigned RAM_DEPTH = 4096;
    localparam int unsigned GPIO_W    = 8;

    localparam logic [31:0] A_CNT_LO   = 32'h1000_0000;
    localparam logic [31:0] A_CNT_HI   = 32'h1000_0004;
    localparam logic [31:0] A_GPIO_OUT = 32'h1000_0008;
    localparam logic [31:0] A_GPIO_IN  = 32'h1000_000C;
    localparam logic [31:0] A_ERR      = 32'h1000_0010;

    logic              clk;
    logic              rst;
    logic              mem_req_in;
    logic              mem_rw_in;
    logic [31:0]       mem_addr_in;
    logic [31:0]       mem_wdata_in;
    logic [31:0]       mem_rdata_out;
    logic [GPIO_W-1:0] gpio_in;
    logic [GPIO_W-1:0] gpio_out;
    logic              err_out;

    core_dmem #(
        .RAM_DEPTH(RAM_DEPTH),
        .GPIO_W   (GPIO_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_in   (mem_req_in),
        .mem_rw_in    (mem_rw_in),
        .mem_addr_in  (mem_addr_in),
        .mem_wdata_in (mem_wdata_in),
        .mem_rdata_out(mem_rdata_out),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .err_out      (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model
    logic [31:0]       mem_m [int unsigned];
    logic [63:0]       m_cnt;
    logic [31:0]       m_shadow;
    logic [GPIO_W-1:0] m_gpio;
    logic              m_err;
    logic [GPIO_W-1:0] m_gq [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = '0;
        m_shadow = '0;
        m_gpio   = '0;
        m_err    = 1'b0;
        m_gq.delete();
        m_gq.push_back('0);
        m_gq.push_back('0);
    endtask

    // 0 unmapped, 1 RAM, 2 CNT_LO, 3 CNT_HI, 4 GPIO_OUT, 5 GPIO_IN, 6 ERR
    function automatic int classify(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (a[31:28] == 4'h0 && w < RAM_DEPTH * 4) return 1;
        if (w == A_CNT_LO)   return 2;
        if (w == A_CNT_HI)   return 3;
        if (w == A_GPIO_OUT) return 4;
        if (w == A_GPIO_IN)  return 5;
        if (w == A_ERR)      return 6;
        return 0;
    endfunction

    // Returns 0 when the expected value is undefined (unwritten RAM).
    function automatic bit exp_read(input logic req, input logic [31:0] a, output logic [31:0] v);
        v = '0;
        if (!req) return 1'b1;
        case (classify(a))
            1: begin
                if (!mem_m.exists(a[31:2])) return 1'b0;
                v = mem_m[a[31:2]];
            end
            2: v = m_cnt[31:0];
            3: v = m_shadow;
            4: v = 32'(m_gpio);
            5: v = 32'(m_gq[0]);
            6: v = {31'b0, m_err};
            default: v = '0;
        endcase
        return 1'b1;
    endfunction

    task automatic model_edge(input logic req, input logic rw, input logic [31:0] a,
                              input logic [31:0] wd, input logic [GPIO_W-1:0] gin);
        logic [63:0] nxt;
        bit          set_e;
        bit          clr_e;
        int          c;
        nxt   = m_cnt + 64'd1;
        set_e = 1'b0;
        clr_e = 1'b0;
        c     = classify(a);
        if (req) begin
            if (c == 0) set_e = 1'b1;
            if (rw) begin
                case (c)
                    1: mem_m[a[31:2]] = wd;
                    2: nxt = {m_cnt[63:32], wd};
                    3: nxt = {wd, m_cnt[31:0]};
                    4: m_gpio = wd[GPIO_W-1:0];
                    6: clr_e = 1'b1;
                    default: ;
                endcase
            end else if (c == 2) begin
                m_shadow = m_cnt[63:32];
            end
        end
        if (set_e) m_err = 1'b1;
        else if (clr_e) m_err = 1'b0;
        m_cnt = nxt;
        void'(m_gq.pop_front());
        m_gq.push_back(gin);
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input logic req, input logic rw, input logic [31:0] a,
                        input logic [31:0] wd, input logic [GPIO_W-1:0] gin,
                        output logic [31:0] rd);
        logic [31:0] ev;
        mem_req_in   = req;
        mem_rw_in    = rw;
        mem_addr_in  = a;
        mem_wdata_in = wd;
        gpio_in      = gin;
        #3;
        rd = mem_rdata_out;
        if (exp_read(req, a, ev)) check_eq("rdata", 64'(rd), 64'(ev));
        check_eq("gpio_out", 64'(gpio_out), 64'(m_gpio));
        check_eq("err_out", 64'(err_out), 64'(m_err));
        @(posedge clk);
        model_edge(req, rw, a, wd, gin);
        #1;
    endtask

    logic [31:0]       rd;
    logic [GPIO_W-1:0] gin_v;

    initial begin
        rst          = 1'b0;
        mem_req_in   = 1'b0;
        mem_rw_in    = 1'b0;
        mem_addr_in  = '0;
        mem_wdata_in = '0;
        gpio_in      = '0;
        gin_v        = '0;
        model_reset();
        #1;
        check_eq("reset_rdata", 64'(mem_rdata_out), 64'h0);
        check_eq("reset_gpio_out", 64'(gpio_out), 64'h0);
        check_eq("reset_err", 64'(err_out), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();

        // RAM write / read-after-write
        step(1, 1, 32'h0000_0010, 32'h1111_1111, gin_v, rd);
        step(1, 1, 32'h0000_0010, 32'hDEAD_BEEF, gin_v, rd);
        check_eq("ram_old_same_cycle", 64'(rd), 64'h1111_1111);
        step(1, 0, 32'h0000_0010, 32'h0, gin_v, rd);
        check_eq("ram_readback", 64'(rd), 64'hDEAD_BEEF);
        step(0, 0, 32'h0000_0010, 32'h0, gin_v, rd);
        check_eq("req_low_zero", 64'(rd), 64'h0);

        // Out-of-range RAM read sets error; ERR write clears
        step(1, 0, 32'h0000_4000, 32'h0, gin_v, rd);
        check_eq("oob_data", 64'(rd), 64'h0);
        check_eq("oob_err_set", 64'(err_out), 64'h1);
        step(1, 0, A_ERR, 32'h0, gin_v, rd);
        check_eq("err_read_set", 64'(rd), 64'h1);
        step(1, 1, A_ERR, 32'h1234_5678, gin_v, rd);
        step(1, 0, A_ERR, 32'h0, gin_v, rd);
        check_eq("err_read_clr", 64'(rd), 64'h0);

        // Counter load with carry, snapshot, stale shadow
        step(1, 1, A_CNT_HI, 32'h0000_0001, gin_v, rd);
        step(1, 1, A_CNT_LO, 32'hFFFF_FFFE, gin_v, rd);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 32'h0, gin_v, rd);
        step(1, 0, A_CNT_LO, 32'h0, gin_v, rd);
        check_eq("cnt_lo_wrapped", 64'(rd), 64'h0000_0001);
        step(1, 0, A_CNT_HI, 32'h0, gin_v, rd);
        check_eq("cnt_hi_carry", 64'(rd), 64'h0000_0002);
        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 32'h0, gin_v, rd);
        step(1, 0, A_CNT_HI, 32'h0, gin_v, rd);
        check_eq("cnt_hi_stale", 64'(rd), 64'h0000_0002);

        // GPIO out and synchronised in
        step(1, 1, A_GPIO_OUT, 32'hFFFF_FFA5, gin_v, rd);
        check_eq("gpio_out_pin", 64'(gpio_out), 64'hA5);
        step(1, 0, A_GPIO_OUT, 32'h0, gin_v, rd);
        check_eq("gpio_out_read", 64'(rd), 64'hA5);
        gin_v = 8'h3C;
        step(1, 0, A_GPIO_IN, 32'h0, gin_v, rd);
        check_eq("gpio_in_lat0", 64'(rd), 64'h0);
        step(1, 0, A_GPIO_IN, 32'h0, gin_v, rd);
        check_eq("gpio_in_lat1", 64'(rd), 64'h0);
        step(1, 0, A_GPIO_IN, 32'h0, gin_v, rd);
        check_eq("gpio_in_lat2", 64'(rd), 64'h3C);

        // Full 64-bit wrap and write-over-increment
        step(1, 1, A_CNT_HI, 32'hFFFF_FFFF, gin_v, rd);
        step(1, 1, A_CNT_LO, 32'hFFFF_FFFF, gin_v, rd);
        step(0, 0, 32'h0, 32'h0, gin_v, rd);
        step(1, 0, A_CNT_LO, 32'h0, gin_v, rd);
        check_eq("wrap_lo", 64'(rd), 64'h0);
        step(1, 0, A_CNT_HI, 32'h0, gin_v, rd);
        check_eq("wrap_hi", 64'(rd), 64'h0);
        step(1, 1, A_CNT_LO, 32'h0000_1000, gin_v, rd);
        step(1, 0, A_CNT_LO, 32'h0, gin_v, rd);
        check_eq("cnt_write_exact", 64'(rd), 64'h0000_1000);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic        req;
            logic        rw;
            int          sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3: a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                4: a = A_CNT_LO;
                5: a = A_CNT_HI;
                6: a = A_GPIO_OUT;
                7: a = A_GPIO_IN;
                8: a = A_ERR;
                default: begin
                    case ($urandom_range(0, 2))
                        0: a = 32'h0000_4000 + {$urandom_range(0, 255), 2'b00};
                        1: a = 32'h2000_0000;
                        default: a = 32'h1000_0014;
                    endcase
                end
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            req = ($urandom_range(0, 9) < 8);
            rw  = ($urandom_range(0, 9) < 3);
            if (($urandom_range(0, 7)) == 0) gin_v = GPIO_W'($urandom);
            step(req, rw, a, $urandom, gin_v, rd);
        end

        // Mid-stream asynchronous reset
        step(1, 1, A_GPIO_OUT, 32'h0000_00A5, gin_v, rd);
        step(1, 0, 32'h3000_0000, 32'h0, gin_v, rd);
        check_eq("pre_rst_gpio", 64'(gpio_out), 64'hA5);
        check_eq("pre_rst_err", 64'(err_out), 64'h1);
        mem_req_in = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_gpio", 64'(gpio_out), 64'h0);
        check_eq("async_rst_err", 64'(err_out), 64'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        step(1, 0, A_CNT_LO, 32'h0, gin_v, rd);
        check_eq("post_rst_cnt", 64'(rd), 64'h0);
        step(1, 0, A_CNT_HI, 32'h0, gin_v, rd);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
